// File: rtl/mdu_pkg.sv
// Shared types and constants for the MDU issue controller.
// Optional divide-by-zero short-circuit is enabled by defining MDU_DIVZERO_CHECK_EN.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_WAIT,
    DIV_SYNC,
    RESP
  } mdu_state_t;

  localparam logic MDU_OP_MUL = 1'b0;
  localparam logic MDU_OP_DIV = 1'b1;

  // Sliced to DATA_WIDTH at the point of use; supports widths up to 64.
  localparam logic [63:0] MDU_DIVZERO_RESULT = '1;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_MUL_LATENCY = 2;
  localparam int unsigned DEFAULT_DIV_LATENCY = 36;

  function automatic int unsigned latency_cnt_width(input int unsigned mul_lat,
                                                    input int unsigned div_lat);
    int unsigned max_lat;
    max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// Down-counter used to time MDU latency; loaded at accept, saturates at zero.
module mdu_latency_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/mdu_issue_controller.sv
// Requester-side sequencer for the multiply/divide unit: accept, hold operands, time, respond.
// Define MDU_DIVZERO_CHECK_EN to short-circuit divides by zero with an all-ones result.
module mdu_issue_controller
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int unsigned DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqOp,
  input  logic [DATA_WIDTH-1:0] iReqSrc0,
  input  logic [DATA_WIDTH-1:0] iReqSrc1,
  input  logic                  iFlush,
  output logic [DATA_WIDTH-1:0] oMduSrc0,
  output logic [DATA_WIDTH-1:0] oMduSrc1,
  output logic                  oMduOperation,
  input  logic [DATA_WIDTH-1:0] iMduResult,
  input  logic                  iMduReady,
  output logic                  oRespValid,
  output logic [DATA_WIDTH-1:0] oRespData,
  input  logic                  iRespReady,
  output logic                  oBusy,
  output logic                  oDivZero
);

  localparam int unsigned CNT_W = latency_cnt_width(MUL_LATENCY, DIV_LATENCY);
  // Counter expires (reads zero) one edge before capture, hence latency minus one.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  mdu_state_t       state;
  logic             req_ready;
  logic             accept;
  logic             flush_active;
  logic             div_zero_req;
  logic             cnt_dec;
  logic             cnt_expired;
  logic [CNT_W-1:0] cnt_load_value;

  always_comb begin
    req_ready      = iRst_n && (state == IDLE) && !iFlush;
    accept         = iReqValid && req_ready;
    flush_active   = iFlush && (state != IDLE);
    cnt_dec        = (state == MUL_WAIT) || (state == DIV_WAIT);
    cnt_load_value = (iReqOp == MDU_OP_DIV) ? DIV_LOAD : MUL_LOAD;
  end

  assign oReqReady = req_ready;

  mdu_latency_counter #(
    .WIDTH(CNT_W)
  ) u_latency_counter (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .load      (accept),
    .load_value(cnt_load_value),
    .dec       (cnt_dec),
    .expired   (cnt_expired)
  );

`ifdef MDU_DIVZERO_CHECK_EN
  logic div_zero_q;

  assign div_zero_req = (iReqOp == MDU_OP_DIV) && (iReqSrc1 == '0);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      div_zero_q <= 1'b0;
    end else if (flush_active) begin
      div_zero_q <= 1'b0;
    end else if (accept) begin
      div_zero_q <= div_zero_req;
    end else if ((state == RESP) && iRespReady) begin
      div_zero_q <= 1'b0;
    end
  end

  assign oDivZero = div_zero_q;
`else
  assign div_zero_req = 1'b0;
  assign oDivZero     = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state         <= IDLE;
      oMduSrc0      <= '0;
      oMduSrc1      <= '0;
      oMduOperation <= MDU_OP_MUL;
      oRespValid    <= 1'b0;
      oRespData     <= '0;
      oBusy         <= 1'b0;
    end else if (flush_active) begin
      // Flush wins over every in-flight transition, including the response handshake.
      state      <= IDLE;
      oRespValid <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            oMduSrc0      <= iReqSrc0;
            oMduSrc1      <= iReqSrc1;
            oMduOperation <= iReqOp;
            oBusy         <= 1'b1;
            if (div_zero_req) begin
              state      <= RESP;
              oRespData  <= MDU_DIVZERO_RESULT[DATA_WIDTH-1:0];
              oRespValid <= 1'b1;
            end else if (iReqOp == MDU_OP_DIV) begin
              state <= DIV_WAIT;
            end else begin
              state <= MUL_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_expired) begin
            oRespData  <= iMduResult;
            oRespValid <= 1'b1;
            state      <= RESP;
          end
        end
        DIV_WAIT: begin
          if (cnt_expired) begin
            state <= DIV_SYNC;
          end
        end
        DIV_SYNC: begin
          if (iMduReady) begin
            oRespData  <= iMduResult;
            oRespValid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (iRespReady) begin
            oRespValid <= 1'b0;
            oBusy      <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          oRespValid <= 1'b0;
          oBusy      <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_controller.sv
// Scoreboard bench for mdu_issue_controller: directed cases plus randomized operations.
module tb_mdu_issue_controller;
  import mdu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned ML = 2;
  localparam int unsigned DL = 36;

  logic          iClk;
  logic          iRst_n;
  logic          iReqValid;
  logic          oReqReady;
  logic          iReqOp;
  logic [DW-1:0] iReqSrc0;
  logic [DW-1:0] iReqSrc1;
  logic          iFlush;
  logic [DW-1:0] oMduSrc0;
  logic [DW-1:0] oMduSrc1;
  logic          oMduOperation;
  logic [DW-1:0] iMduResult;
  logic          iMduReady;
  logic          oRespValid;
  logic [DW-1:0] oRespData;
  logic          iRespReady;
  logic          oBusy;
  logic          oDivZero;

  mdu_issue_controller #(
    .DATA_WIDTH (DW),
    .MUL_LATENCY(ML),
    .DIV_LATENCY(DL)
  ) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iReqValid    (iReqValid),
    .oReqReady    (oReqReady),
    .iReqOp       (iReqOp),
    .iReqSrc0     (iReqSrc0),
    .iReqSrc1     (iReqSrc1),
    .iFlush       (iFlush),
    .oMduSrc0     (oMduSrc0),
    .oMduSrc1     (oMduSrc1),
    .oMduOperation(oMduOperation),
    .iMduResult   (iMduResult),
    .iMduReady    (iMduReady),
    .oRespValid   (oRespValid),
    .oRespData    (oRespData),
    .iRespReady   (iRespReady),
    .oBusy        (oBusy),
    .oDivZero     (oDivZero)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int unsigned cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          dz;
    int unsigned   due;
  } exp_t;

  exp_t sb[$];

  // Environment state shared between stimulus, MDU model and monitor.
  int unsigned   div_min_edge = 0;
  int unsigned   rdy_edge     = 0;
  bit            hold_resp    = 1'b0;
  bit            track_ops    = 1'b0;
  logic [DW-1:0] exp_src0, exp_src1;
  logic          exp_op;
  bit            in_resp      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] ref_result(input logic op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [2*DW-1:0] prod;
    if (op == MDU_OP_MUL) begin
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return prod[DW-1:0];
    end
    if (b == '0) return '1;
    return a / b;
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Behavioural MDU plus random response backpressure.
  initial begin
    iMduReady  = 1'b0;
    iMduResult = '0;
    iRespReady = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      if (oMduOperation == MDU_OP_DIV) begin
        if (cyc + 1 >= div_min_edge) iMduReady = (cyc + 1 >= rdy_edge);
        else iMduReady = 1'($urandom_range(0, 1));
        iMduResult = iMduReady ? ref_result(MDU_OP_DIV, oMduSrc0, oMduSrc1) : DW'($urandom);
      end else begin
        iMduReady  = 1'($urandom_range(0, 1));
        iMduResult = ref_result(MDU_OP_MUL, oMduSrc0, oMduSrc1);
      end
      iRespReady = hold_resp ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on each response and watches operand stability.
  initial begin
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        in_resp = 1'b0;
      end else begin
        if (track_ops && oBusy) begin
          check("mdu_src0_stable", 64'(oMduSrc0), 64'(exp_src0));
          check("mdu_src1_stable", 64'(oMduSrc1), 64'(exp_src1));
          check("mdu_op_stable", 64'(oMduOperation), 64'(exp_op));
        end
        if (oRespValid) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_resp");
          end else if (!in_resp) begin
            in_resp = 1'b1;
            check("resp_latency", 64'(cyc), 64'(sb[0].due));
            check("resp_data", 64'(oRespData), 64'(sb[0].data));
            check("resp_divzero", 64'(oDivZero), 64'(sb[0].dz));
            check("busy_in_resp", 64'(oBusy), 64'd1);
          end else begin
            check("resp_hold", 64'(oRespData), 64'(sb[0].data));
          end
          if (iRespReady) begin
            if (sb.size() > 0) void'(sb.pop_front());
            in_resp = 1'b0;
          end
        end else begin
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int unsigned k, input bit expect_resp);
    exp_t        e;
    int unsigned guard;
    int unsigned t0;
    guard = 0;
    while (!oReqReady && guard < 300) begin
      tick();
      guard++;
    end
    if (!oReqReady) begin
      fail_now("req_ready_timeout");
      return;
    end
    t0           = cyc + 1;
    div_min_edge = t0 + DL + 1;
    rdy_edge     = div_min_edge + k;
    e.data       = ref_result(op, a, b);
    e.dz         = 1'b0;
    e.due        = (op == MDU_OP_DIV) ? rdy_edge : t0 + ML;
`ifdef MDU_DIVZERO_CHECK_EN
    if (op == MDU_OP_DIV && b == '0) begin
      e.dz  = 1'b1;
      e.due = t0 + 1;
    end
`endif
    if (expect_resp) sb.push_back(e);
    iReqValid = 1'b1;
    iReqOp    = op;
    iReqSrc0  = a;
    iReqSrc1  = b;
    tick();
    exp_src0  = a;
    exp_src1  = b;
    exp_op    = op;
    track_ops = 1'b1;
    iReqValid = 1'b0;
    iReqSrc0  = DW'($urandom);
    iReqSrc1  = DW'($urandom);
    iReqOp    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int unsigned guard;
    guard = 0;
    while ((oBusy || sb.size() != 0) && guard < 300) begin
      tick();
      guard++;
    end
    if (oBusy || sb.size() != 0) fail_now(name);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic          op;
    iRst_n    = 1'b0;
    iReqValid = 1'b0;
    iReqOp    = 1'b0;
    iReqSrc0  = '0;
    iReqSrc1  = '0;
    iFlush    = 1'b0;

    #3;
    check("rst_req_ready", 64'(oReqReady), 64'd0);
    check("rst_resp_valid", 64'(oRespValid), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    #19;
    iRst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 64'(oReqReady), 64'd1);
    tick();

    // Multiply 7 x 6.
    do_op(MDU_OP_MUL, 32'd7, 32'd6, 0, 1'b1);
    wait_idle("mul_drain_timeout");

    // Divide 100 / 7 with divider ready arriving 40 edges after accept.
    do_op(MDU_OP_DIV, 32'd100, 32'd7, 40 - (DL + 1), 1'b1);
    wait_idle("div_drain_timeout");

    // Backpressure: response must hold while the consumer stalls.
    hold_resp = 1'b1;
    tick();
    do_op(MDU_OP_MUL, 32'hFFFF_FFFF, 32'd2, 0, 1'b1);
    for (int i = 0; i < 10 && !oRespValid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(oRespValid), 64'd1);
      check("bp_data", 64'(oRespData), 64'hFFFF_FFFE);
      check("bp_req_ready", 64'(oReqReady), 64'd0);
      tick();
    end
    hold_resp = 1'b0;
    wait_idle("bp_drain_timeout");
    check("bp_idle_ready", 64'(oReqReady), 64'd1);

    // Divide by zero.
    do_op(MDU_OP_DIV, 32'd5, 32'd0, 1, 1'b1);
    wait_idle("dz_drain_timeout");

    // Flush in IDLE gates ready and accepts nothing.
    iFlush    = 1'b1;
    iReqValid = 1'b1;
    #1;
    check("idle_flush_ready", 64'(oReqReady), 64'd0);
    tick();
    check("idle_flush_busy", 64'(oBusy), 64'd0);
    iFlush    = 1'b0;
    iReqValid = 1'b0;

    // Flush at cycle 10 of a divide, then a fresh multiply.
    do_op(MDU_OP_DIV, 32'd50, 32'd3, 2, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    iFlush = 1'b1;
    tick();
    iFlush = 1'b0;
    check("flush_busy", 64'(oBusy), 64'd0);
    check("flush_valid", 64'(oRespValid), 64'd0);
    for (int i = 0; i < 45; i++) begin
      tick();
      if (oRespValid) fail_now("flush_stale_resp");
    end
    do_op(MDU_OP_MUL, 32'd1234, 32'd5678, 0, 1'b1);
    wait_idle("post_flush_drain_timeout");

    // Asynchronous reset in the middle of a divide.
    do_op(MDU_OP_DIV, 32'd999, 32'd9, 0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #2;
    iRst_n = 1'b0;
    #1;
    check("arst_src0", 64'(oMduSrc0), 64'd0);
    check("arst_src1", 64'(oMduSrc1), 64'd0);
    check("arst_op", 64'(oMduOperation), 64'd0);
    check("arst_valid", 64'(oRespValid), 64'd0);
    check("arst_data", 64'(oRespData), 64'd0);
    check("arst_busy", 64'(oBusy), 64'd0);
    check("arst_divzero", 64'(oDivZero), 64'd0);
    check("arst_ready", 64'(oReqReady), 64'd0);
    tick();
    tick();
    iRst_n = 1'b1;
    #1;
    check("arst_release_ready", 64'(oReqReady), 64'd1);
    for (int i = 0; i < 45; i++) begin
      tick();
      if (oRespValid || oBusy) fail_now("arst_stale_resp");
    end

    // Randomized operations.
    for (int n = 0; n < 30; n++) begin
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1, 2:    b = DW'($urandom_range(1, 50));
        default: b = DW'($urandom);
      endcase
      do_op(op, a, b, $urandom_range(0, 4), 1'b1);
    end
    wait_idle("final_drain_timeout");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
